// File: rtl/dmcpy_pkg.sv
// Shared types and constants for the data-memory copy/fill engine.
// Fill support is compiled in only when DMCPY_FILL_EN is defined.
package dmcpy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam int BYTEEN_W = 4;

endpackage

// File: rtl/dmcpy_lane_mask.sv
// Byte-lane mask for one bus word: lanes from the start lane (offset on the
// first word, 0 afterwards) up to but excluding start + bytes_left.
module dmcpy_lane_mask
    import dmcpy_pkg::*;
(
    input  logic [1:0]          offset,
    input  logic                first,
    input  logic [15:0]         bytes_left,
    output logic [BYTEEN_W-1:0] byteen
);

    logic [17:0] lane_lo;
    logic [17:0] lane_end;

    always_comb begin
        lane_lo  = first ? {16'd0, offset} : 18'd0;
        lane_end = lane_lo + {2'b00, bytes_left};
        byteen   = '0;
        for (int k = 0; k < BYTEEN_W; k++) begin
            byteen[k] = (18'(k) >= lane_lo) && (18'(k) < lane_end);
        end
    end

endmodule

// File: rtl/dm_copy_engine.sv
// Data-memory bus initiator that copies or fills byte ranges word by word.
// Define DMCPY_FILL_EN to enable fill mode; otherwise mode=1 is rejected.
module dm_copy_engine
    import dmcpy_pkg::*;
#(
    parameter logic [31:0] ENGINE_TAG = 32'h0000_7f00
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [31:0]         src_addr,
    input  logic [31:0]         dst_addr,
    input  logic [15:0]         byte_len,
    input  logic [31:0]         fill_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         m_data_addr,
    output logic [31:0]         m_data_wdata,
    output logic [BYTEEN_W-1:0] m_data_byteen,
    input  logic [31:0]         m_data_rdata,
    output logic [31:0]         m_inst_addr
);

    state_t              state;
    logic                first_q;
    logic [1:0]          off_q;
    logic [15:0]         left_q;
    logic [31:0]         src_q;
    logic [31:0]         dst_q;
    logic [31:0]         rdata_q;
    logic [BYTEEN_W-1:0] lane_mask;
    logic [15:0]         step;
    logic                last_word;
`ifdef DMCPY_FILL_EN
    logic                mode_q;
    logic [31:0]         fill_q;
`else
    logic                unused_fill;
    assign unused_fill = ^fill_data;
`endif

    dmcpy_lane_mask u_lane_mask (
        .offset     (off_q),
        .first      (first_q),
        .bytes_left (left_q),
        .byteen     (lane_mask)
    );

    // Bytes this word consumes; the first word starts at the destination offset.
    assign step      = first_q ? (16'd4 - {14'd0, off_q}) : 16'd4;
    assign last_word = (left_q <= step);

    assign m_inst_addr = ENGINE_TAG;

    always_comb begin
        m_data_addr   = '0;
        m_data_wdata  = '0;
        m_data_byteen = '0;
        case (state)
            RD: m_data_addr = src_q;
            WR: begin
                m_data_addr   = dst_q;
                // Gate with reset so no write lands on an edge that resets us.
                m_data_byteen = lane_mask & {BYTEEN_W{reset}};
`ifdef DMCPY_FILL_EN
                m_data_wdata  = (mode_q == MODE_FILL) ? fill_q : rdata_q;
`else
                m_data_wdata  = rdata_q;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            first_q <= 1'b0;
            off_q   <= 2'd0;
            left_q  <= 16'd0;
            src_q   <= 32'd0;
            dst_q   <= 32'd0;
            rdata_q <= 32'd0;
`ifdef DMCPY_FILL_EN
            mode_q  <= MODE_COPY;
            fill_q  <= 32'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q   <= {src_addr[31:2], 2'b00};
                        dst_q   <= {dst_addr[31:2], 2'b00};
                        off_q   <= dst_addr[1:0];
                        left_q  <= byte_len;
                        first_q <= 1'b1;
                        err     <= 1'b0;
`ifdef DMCPY_FILL_EN
                        mode_q  <= mode;
                        fill_q  <= fill_data;
`endif
                        if (byte_len == 16'd0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (mode == MODE_COPY && src_addr[1:0] != dst_addr[1:0]) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (mode == MODE_FILL) begin
`ifdef DMCPY_FILL_EN
                            state <= WR;
                            busy  <= 1'b1;
`else
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
`endif
                        end else begin
                            state <= RD;
                            busy  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    rdata_q <= m_data_rdata;
                    state   <= WR;
                end
                WR: begin
                    src_q   <= src_q + 32'd4;
                    dst_q   <= dst_q + 32'd4;
                    first_q <= 1'b0;
                    left_q  <= left_q - step;
                    if (last_word) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
`ifdef DMCPY_FILL_EN
                        state <= (mode_q == MODE_FILL) ? WR : RD;
`else
                        state <= RD;
`endif
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Self-checking bench for dm_copy_engine with a byte-level reference memory;
// expectations adapt to whether DMCPY_FILL_EN is defined.
module tb_dm_copy_engine;

`ifdef DMCPY_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] byte_len;
  logic [31:0] fill_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic [31:0] m_inst_addr;

  int pass_cnt;
  int total_cnt;

  // bus slave memory (1 KiB) and byte-level reference image
  logic [31:0] mem [256];
  logic [7:0]  ref_mem [1024];
  int          wr_count;
  logic [31:0] log_addr_q[$];
  logic [31:0] log_data_q[$];
  logic [3:0]  log_be_q[$];

  dm_copy_engine dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mode          (mode),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .byte_len      (byte_len),
    .fill_data     (fill_data),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata),
    .m_inst_addr   (m_inst_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_data_rdata = mem[m_data_addr[9:2]];

  always @(posedge clk) begin
    if (m_data_byteen != 4'b0000) begin
      for (int k = 0; k < 4; k++)
        if (m_data_byteen[k]) mem[m_data_addr[9:2]][8*k +: 8] = m_data_wdata[8*k +: 8];
      wr_count++;
      log_addr_q.push_back(m_data_addr);
      log_data_q.push_back(m_data_wdata);
      log_be_q.push_back(m_data_byteen);
    end
  end

  function automatic int mem_diffs();
    int d;
    d = 0;
    for (int w = 0; w < 256; w++)
      if (mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) d++;
    return d;
  endfunction

  task automatic clear_log();
    wr_count = 0;
    log_addr_q.delete();
    log_data_q.delete();
    log_be_q.delete();
  endtask

  // reference model: byte-by-byte effect plus expected status/latency/writes
  task automatic model_op(input logic md, input logic [31:0] sa, input logic [31:0] da,
                          input logic [15:0] ln, input logic [31:0] fd,
                          output logic e_err, output int e_lat, output int e_wr);
    int nw;
    logic [9:0] s;
    logic [9:0] d;
    nw = (int'(da[1:0]) + int'(ln) + 3) / 4;
    if (ln == 16'd0) begin
      e_err = 1'b0; e_lat = 1; e_wr = 0;
    end else if (md == 1'b0 && sa[1:0] != da[1:0]) begin
      e_err = 1'b1; e_lat = 1; e_wr = 0;
    end else if (md == 1'b1 && !FILL_EN) begin
      e_err = 1'b1; e_lat = 1; e_wr = 0;
    end else begin
      e_err = 1'b0;
      e_wr  = nw;
      e_lat = md ? nw + 1 : 2 * nw + 1;
      for (int i = 0; i < int'(ln); i++) begin
        s = sa[9:0] + 10'(i);
        d = da[9:0] + 10'(i);
        if (md) ref_mem[d] = fd[8*int'(d[1:0]) +: 8];
        else    ref_mem[d] = ref_mem[s];
      end
    end
  endtask

  // driver: issue one request and count cycles until done
  task automatic run_op(input logic md, input logic [31:0] sa, input logic [31:0] da,
                        input logic [15:0] ln, input logic [31:0] fd,
                        output int lat, output logic err_o);
    int n;
    mode = md; src_addr = sa; dst_addr = da; byte_len = ln; fill_data = fd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    err_o = err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
    total_cnt++; if (m_data_addr !== 32'd0) $display("FAIL reset_addr got %h want 0", m_data_addr); else pass_cnt++;
    total_cnt++; if (m_data_wdata !== 32'd0) $display("FAIL reset_wdata got %h want 0", m_data_wdata); else pass_cnt++;
    total_cnt++; if (m_data_byteen !== 4'd0) $display("FAIL reset_byteen got %b want 0", m_data_byteen); else pass_cnt++;
    total_cnt++; if (m_inst_addr !== 32'h0000_7f00) $display("FAIL inst_tag got %h want 00007f00", m_inst_addr); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_directed();
    int lat; logic e; logic e_err; int e_lat; int e_wr;
    clear_log();
    model_op(1'b1, 32'h0, 32'h100, 16'd8, 32'hDEADBEEF, e_err, e_lat, e_wr);
    run_op(1'b1, 32'h0, 32'h100, 16'd8, 32'hDEADBEEF, lat, e);
    total_cnt++; if (lat !== e_lat) $display("FAIL fill_latency got %0d want %0d", lat, e_lat); else pass_cnt++;
    total_cnt++; if (e !== e_err) $display("FAIL fill_err got %b want %b", e, e_err); else pass_cnt++;
    total_cnt++; if (wr_count !== e_wr) $display("FAIL fill_writes got %0d want %0d", wr_count, e_wr); else pass_cnt++;
    if (FILL_EN && wr_count == 2) begin
      total_cnt++;
      if (log_addr_q[0] !== 32'h100 || log_be_q[0] !== 4'b1111 || log_data_q[0] !== 32'hDEADBEEF)
        $display("FAIL fill_w0 got %h/%b/%h want 100/1111/deadbeef", log_addr_q[0], log_be_q[0], log_data_q[0]);
      else pass_cnt++;
      total_cnt++;
      if (log_addr_q[1] !== 32'h104 || log_be_q[1] !== 4'b1111 || log_data_q[1] !== 32'hDEADBEEF)
        $display("FAIL fill_w1 got %h/%b/%h want 104/1111/deadbeef", log_addr_q[1], log_be_q[1], log_data_q[1]);
      else pass_cnt++;
    end
    total_cnt++; if (mem_diffs() !== 0) $display("FAIL fill_mem got %0d diffs want 0", mem_diffs()); else pass_cnt++;
  endtask

  task automatic test_copy_directed();
    int lat; logic e; logic e_err; int e_lat; int e_wr;
    logic [7:0] old0; logic [7:0] old3;
    mem[32'h200 >> 2] = 32'h44332211;
    mem[32'h204 >> 2] = 32'h88776655;
    {ref_mem[32'h203], ref_mem[32'h202], ref_mem[32'h201], ref_mem[32'h200]} = 32'h44332211;
    {ref_mem[32'h207], ref_mem[32'h206], ref_mem[32'h205], ref_mem[32'h204]} = 32'h88776655;
    old0 = ref_mem[32'h300];
    old3 = ref_mem[32'h307];
    clear_log();
    model_op(1'b0, 32'h201, 32'h301, 16'd6, 32'h0, e_err, e_lat, e_wr);
    run_op(1'b0, 32'h201, 32'h301, 16'd6, 32'h0, lat, e);
    total_cnt++; if (lat !== 5) $display("FAIL copy_latency got %0d want 5", lat); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL copy_err got %b want 0", e); else pass_cnt++;
    total_cnt++; if (wr_count !== 2) $display("FAIL copy_writes got %0d want 2", wr_count); else pass_cnt++;
    if (wr_count == 2) begin
      total_cnt++;
      if (log_addr_q[0] !== 32'h300 || log_be_q[0] !== 4'b1110)
        $display("FAIL copy_w0 got %h/%b want 300/1110", log_addr_q[0], log_be_q[0]);
      else pass_cnt++;
      total_cnt++;
      if (log_addr_q[1] !== 32'h304 || log_be_q[1] !== 4'b0111)
        $display("FAIL copy_w1 got %h/%b want 304/0111", log_addr_q[1], log_be_q[1]);
      else pass_cnt++;
    end
    total_cnt++; if (mem[32'h300 >> 2] !== {24'h443322, old0}) $display("FAIL copy_word300 got %h want %h", mem[32'h300 >> 2], {24'h443322, old0}); else pass_cnt++;
    total_cnt++; if (mem[32'h304 >> 2] !== {old3, 24'h776655}) $display("FAIL copy_word304 got %h want %h", mem[32'h304 >> 2], {old3, 24'h776655}); else pass_cnt++;
    total_cnt++; if (mem_diffs() !== 0) $display("FAIL copy_mem got %0d diffs want 0", mem_diffs()); else pass_cnt++;
  endtask

  task automatic test_zero_len_and_misaligned();
    int lat; logic e;
    clear_log();
    run_op(1'b0, 32'h10, 32'h210, 16'd0, 32'h0, lat, e);
    total_cnt++; if (lat !== 1) $display("FAIL zero_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL zero_err got %b want 0", e); else pass_cnt++;
    total_cnt++; if (wr_count !== 0) $display("FAIL zero_writes got %0d want 0", wr_count); else pass_cnt++;
    clear_log();
    run_op(1'b0, 32'h200, 32'h302, 16'd8, 32'h0, lat, e);
    total_cnt++; if (lat !== 1) $display("FAIL misalign_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (e !== 1'b1) $display("FAIL misalign_err got %b want 1", e); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL misalign_err_held got %b want 1", err); else pass_cnt++;
    total_cnt++; if (wr_count !== 0) $display("FAIL misalign_writes got %0d want 0", wr_count); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic e_err; int e_lat; int e_wr; bit saw_done;
    clear_log();
    mode = 1'b0; src_addr = 32'h100; dst_addr = 32'h380; byte_len = 16'd16; fill_data = 32'h0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
    saw_done = 1'b0;
    repeat (6) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    repeat (4) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    total_cnt++; if (saw_done !== 1'b0) $display("FAIL abort_done got %b want 0", saw_done); else pass_cnt++;
    total_cnt++; if (wr_count !== 1) $display("FAIL abort_writes got %0d want 1", wr_count); else pass_cnt++;
    model_op(1'b0, 32'h100, 32'h380, 16'd4, 32'h0, e_err, e_lat, e_wr);
    total_cnt++; if (mem_diffs() !== 0) $display("FAIL abort_mem got %0d diffs want 0", mem_diffs()); else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    logic e_err; int e_lat; int e_wr; int n;
    clear_log();
    model_op(1'b0, 32'h040, 32'h240, 16'd12, 32'h0, e_err, e_lat, e_wr);
    mode = 1'b0; src_addr = 32'h040; dst_addr = 32'h240; byte_len = 16'd12; fill_data = 32'h0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    mode = 1'b1; src_addr = 32'h0; dst_addr = 32'h3a0; byte_len = 16'd8; fill_data = 32'hA5A5_5A5A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++; if (n !== e_lat) $display("FAIL busy_start_latency got %0d want %0d", n, e_lat); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (wr_count !== e_wr) $display("FAIL busy_start_writes got %0d want %0d", wr_count, e_wr); else pass_cnt++;
    total_cnt++; if (mem_diffs() !== 0) $display("FAIL busy_start_mem got %0d diffs want 0", mem_diffs()); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL busy_start_idle_done got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_start_in_fin();
    mode = 1'b0; src_addr = 32'h0; dst_addr = 32'h200; byte_len = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b1) $display("FAIL fin_first_done got %b want 1", done); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL fin_ignored_done got %b want 0", done); else pass_cnt++;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++; if (done !== 1'b1) $display("FAIL fin_retry_done got %b want 1", done); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic e; logic e_err; int e_lat; int e_wr;
    logic md; logic [31:0] sa; logic [31:0] da; logic [15:0] ln; logic [31:0] fd;
    for (int t = 0; t < 24; t++) begin
      md = 1'($urandom_range(0, 1));
      sa = 32'($urandom_range(0, 32'h17f));
      da = 32'($urandom_range(32'h200, 32'h3bf));
      if ($urandom_range(0, 3) != 0) da[1:0] = sa[1:0];
      ln = 16'($urandom_range(0, 48));
      if ($urandom_range(0, 9) == 0) ln = 16'd0;
      fd = $urandom;
      clear_log();
      model_op(md, sa, da, ln, fd, e_err, e_lat, e_wr);
      run_op(md, sa, da, ln, fd, lat, e);
      total_cnt++; if (lat !== e_lat) $display("FAIL rand%0d_latency got %0d want %0d", t, lat, e_lat); else pass_cnt++;
      total_cnt++; if (e !== e_err) $display("FAIL rand%0d_err got %b want %b", t, e, e_err); else pass_cnt++;
      total_cnt++; if (wr_count !== e_wr) $display("FAIL rand%0d_writes got %0d want %0d", t, wr_count, e_wr); else pass_cnt++;
      total_cnt++; if (mem_diffs() !== 0) $display("FAIL rand%0d_mem got %0d diffs want 0", t, mem_diffs()); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rand%0d_busy got %b want 0", t, busy); else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    wr_count = 0;
    reset = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    src_addr = 32'h0;
    dst_addr = 32'h0;
    byte_len = 16'h0;
    fill_data = 32'h0;
    for (int w = 0; w < 256; w++) begin
      mem[w] = $urandom;
      {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]} = mem[w];
    end

    test_reset();
    test_fill_directed();
    test_copy_directed();
    test_zero_len_and_misaligned();
    test_reset_abort();
    test_start_while_busy();
    test_start_in_fin();
    test_random();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
